// File: rtl/pakin_pkg.sv
// Shared sizing, message layout and FSM state types for the packet-to-message reassembler.
package pakin_pkg;

   localparam int unsigned Asz      = 6;
   localparam int unsigned Dsz      = 8;
   localparam int unsigned Rsz      = 4;
   localparam int unsigned Psz      = 10;
   localparam int unsigned Fsz      = 4;
   localparam int unsigned NsReqCks = 2;
   localparam int unsigned NsAckCks = 2;

   localparam int unsigned Msz    = 2 * Asz + Dsz + Rsz;
   localparam int unsigned TotPks = Msz / Psz + 1;
   localparam int unsigned Iw     = ($clog2(TotPks) > 1) ? $clog2(TotPks) : 1;
   // Raw bit span of all packets of one message, including last-packet padding.
   localparam int unsigned Bw     = TotPks * Psz;

   typedef struct packed {
      logic [Asz-1:0] src;
      logic [Asz-1:0] dst;
      logic [Dsz-1:0] dat;
      logic [Rsz-1:0] red;
   } msg_t;

   typedef enum logic {
      StRxIdle,
      StRxAck
   } rx_state_e;

   typedef enum logic [1:0] {
      StTxIdle,
      StTxOffer,
      StTxDrain
   } tx_state_e;

   function automatic int unsigned cnt_width(input int unsigned cks);
      return (cks > 1) ? $clog2(cks) : 1;
   endfunction

endpackage

// File: rtl/pakin_if.sv
// Packet-in and message-out 4-phase channels; master is the environment, slave is pakin.
interface pakin_if;
   import pakin_pkg::*;

   logic [Iw+Psz-1:0] rcv0_pakio;
   logic              rcv0_req;
   logic              rcv0_ack;
   logic [Asz-1:0]    snd0_src;
   logic [Asz-1:0]    snd0_dst;
   logic [Dsz-1:0]    snd0_dat;
   logic [Rsz-1:0]    snd0_red;
   logic              snd0_req;
   logic              snd0_ack;

   modport master (
      output rcv0_pakio,
      output rcv0_req,
      input  rcv0_ack,
      input  snd0_src,
      input  snd0_dst,
      input  snd0_dat,
      input  snd0_red,
      input  snd0_req,
      output snd0_ack
   );

   modport slave (
      input  rcv0_pakio,
      input  rcv0_req,
      output rcv0_ack,
      output snd0_src,
      output snd0_dst,
      output snd0_dat,
      output snd0_red,
      output snd0_req,
      input  snd0_ack
   );

endinterface

// File: rtl/pakin_msg_fifo.sv
// Message FIFO with wrap-bit pointers; synchronous active-low reset clears pointers and storage.
module pakin_msg_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 24
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [PtrW:0] PtrOne = 1;

   logic [PtrW:0]    wr_ptr_q, rd_ptr_q;
   logic [Width-1:0] mem_q [Depth];
   logic             do_push, do_pop;

   always_comb begin
      empty_o = (wr_ptr_q == rd_ptr_q);
      // Same slot with differing wrap bits means the writer lapped the reader.
      full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
      do_push = push_i && !full_o;
      do_pop  = pop_i && !empty_o;
      rdata_o = mem_q[rd_ptr_q[PtrW-1:0]];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
            wr_ptr_q                  <= wr_ptr_q + PtrOne;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PtrOne;
         end
      end
   end

endmodule

// File: rtl/pakin.sv
// Packet-to-message reassembler: debounced packet channel in, FIFO-buffered message channel out.
module pakin
   import pakin_pkg::*;
#(
   parameter int unsigned RcvReqCks = NsReqCks,
   parameter int unsigned SndAckCks = NsAckCks
) (
   input  logic    i_clk,
   input  logic    reset,
   output logic    ready,
   output logic    err,
   pakin_if.slave  chnl
);

   localparam int unsigned RcvCntW = cnt_width(RcvReqCks);
   localparam int unsigned SndCntW = cnt_width(SndAckCks);
   localparam logic [RcvCntW-1:0] RcvCntMax = RcvCntW'(RcvReqCks - 1);
   localparam logic [SndCntW-1:0] SndCntMax = SndCntW'(SndAckCks - 1);
   localparam logic [RcvCntW-1:0] RcvCntOne = 1;
   localparam logic [SndCntW-1:0] SndCntOne = 1;
   localparam logic [Iw-1:0]      LastIdx   = Iw'(TotPks - 1);
   localparam logic [Iw-1:0]      IdxOne    = 1;

   logic               rg_rdy_q;
   logic               req_db_q, req_rdy_q;
   logic [RcvCntW-1:0] req_cnt_q;
   logic               ack_db_q, ack_rdy_q;
   logic [SndCntW-1:0] ack_cnt_q;

   rx_state_e          rx_state_q;
   logic               rcv_ack_q, err_q;
   logic [Iw-1:0]      exp_q;
   logic [Psz-1:0]     pkt_q [TotPks];

   tx_state_e          tx_state_q;
   logic               snd_req_q;
   msg_t               snd_msg_q;

   logic [Iw-1:0]      pkt_idx;
   logic [Psz-1:0]     pkt_pay;
   logic [Bw-1:0]      asm_bits;
   logic [Msz-1:0]     push_msg;
   msg_t               head_msg;
   logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic               unused_pad;

   assign pkt_idx = chnl.rcv0_pakio[Psz +: Iw];
   assign pkt_pay = chnl.rcv0_pakio[Psz-1:0];

   always_ff @(posedge i_clk) begin
      if (!reset) begin
         rg_rdy_q <= 1'b0;
      end else begin
         rg_rdy_q <= 1'b1;
      end
   end

   // A level change only propagates after RcvReqCks consecutive differing samples.
   always_ff @(posedge i_clk) begin
      if (!reset) begin
         req_db_q  <= 1'b0;
         req_cnt_q <= '0;
         req_rdy_q <= 1'b0;
      end else begin
         req_rdy_q <= 1'b1;
         if (chnl.rcv0_req == req_db_q) begin
            req_cnt_q <= '0;
         end else if (req_cnt_q == RcvCntMax) begin
            req_db_q  <= chnl.rcv0_req;
            req_cnt_q <= '0;
         end else begin
            req_cnt_q <= req_cnt_q + RcvCntOne;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!reset) begin
         ack_db_q  <= 1'b0;
         ack_cnt_q <= '0;
         ack_rdy_q <= 1'b0;
      end else begin
         ack_rdy_q <= 1'b1;
         if (chnl.snd0_ack == ack_db_q) begin
            ack_cnt_q <= '0;
         end else if (ack_cnt_q == SndCntMax) begin
            ack_db_q  <= chnl.snd0_ack;
            ack_cnt_q <= '0;
         end else begin
            ack_cnt_q <= ack_cnt_q + SndCntOne;
         end
      end
   end

   // Stored packets fill the low slots; the packet on the bus completes the top slot.
   always_comb begin
      asm_bits = '0;
      for (int k = 0; k < int'(TotPks) - 1; k++) begin
         asm_bits[k*Psz +: Psz] = pkt_q[k];
      end
      asm_bits[(TotPks-1)*Psz +: Psz] = pkt_pay;
   end

   assign push_msg   = asm_bits[Msz-1:0];
   assign unused_pad = ^asm_bits[Bw-1:Msz];

   assign fifo_push = rg_rdy_q && (rx_state_q == StRxIdle) && req_db_q &&
                      (pkt_idx == exp_q) && (exp_q == LastIdx) && !fifo_full;
   assign fifo_pop  = (tx_state_q == StTxOffer) && ack_db_q;

   pakin_msg_fifo #(
      .Depth (Fsz),
      .Width (Msz)
   ) u_fifo (
      .clk_i   (i_clk),
      .rst_ni  (reset),
      .push_i  (fifo_push),
      .wdata_i (push_msg),
      .pop_i   (fifo_pop),
      .rdata_o (head_msg),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge i_clk) begin
      if (!reset) begin
         rx_state_q <= StRxIdle;
         rcv_ack_q  <= 1'b0;
         err_q      <= 1'b0;
         exp_q      <= '0;
         for (int k = 0; k < int'(TotPks); k++) begin
            pkt_q[k] <= '0;
         end
      end else begin
         err_q <= 1'b0;
         unique case (rx_state_q)
            StRxIdle: begin
               if (rg_rdy_q && req_db_q) begin
                  if (pkt_idx == exp_q) begin
                     if (exp_q != LastIdx) begin
                        pkt_q[exp_q] <= pkt_pay;
                        exp_q        <= exp_q + IdxOne;
                        rcv_ack_q    <= 1'b1;
                        rx_state_q   <= StRxAck;
                     end else if (!fifo_full) begin
                        exp_q      <= '0;
                        rcv_ack_q  <= 1'b1;
                        rx_state_q <= StRxAck;
                     end
                  end else begin
                     // Out of sequence: drop the partial, but a fresh index 0 starts a new one.
                     err_q      <= 1'b1;
                     rcv_ack_q  <= 1'b1;
                     rx_state_q <= StRxAck;
                     if (pkt_idx == '0) begin
                        pkt_q[0] <= pkt_pay;
                        exp_q    <= IdxOne;
                     end else begin
                        exp_q <= '0;
                     end
                  end
               end
            end
            StRxAck: begin
               if (!req_db_q) begin
                  rcv_ack_q  <= 1'b0;
                  rx_state_q <= StRxIdle;
               end
            end
            default: rx_state_q <= StRxIdle;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!reset) begin
         tx_state_q <= StTxIdle;
         snd_req_q  <= 1'b0;
         snd_msg_q  <= '0;
      end else begin
         unique case (tx_state_q)
            StTxIdle: begin
               if (rg_rdy_q && !ack_db_q && !fifo_empty) begin
                  snd_msg_q  <= head_msg;
                  snd_req_q  <= 1'b1;
                  tx_state_q <= StTxOffer;
               end
            end
            StTxOffer: begin
               if (ack_db_q) begin
                  snd_req_q  <= 1'b0;
                  tx_state_q <= StTxDrain;
               end
            end
            StTxDrain: begin
               if (!ack_db_q) begin
                  tx_state_q <= StTxIdle;
               end
            end
            default: tx_state_q <= StTxIdle;
         endcase
      end
   end

   assign chnl.rcv0_ack = rcv_ack_q;
   assign chnl.snd0_req = snd_req_q;
   assign chnl.snd0_src = snd_msg_q.src;
   assign chnl.snd0_dst = snd_msg_q.dst;
   assign chnl.snd0_dat = snd_msg_q.dat;
   assign chnl.snd0_red = snd_msg_q.red;
   assign err           = err_q;
   assign ready         = rg_rdy_q && req_rdy_q && ack_rdy_q;

endmodule

// File: tb/tb_pakin.sv
// Directed bench for pakin: vector table of messages plus hand-written handshake corner cases.
module tb_pakin;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ready;
   logic        err;
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   pakin_if bus ();

   pakin u_dut (
      .i_clk (clk),
      .reset (rst_n),
      .ready (ready),
      .err   (err),
      .chnl  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] m;
      logic [5:0]  src;
      logic [5:0]  dst;
      logic [7:0]  dat;
      logic [3:0]  red;
   } vec_t;

   vec_t vecs [5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [9:0] pkt_of(input logic [23:0] m, input int k);
      logic [29:0] mp;
      mp = {6'b0, m};
      return mp[k*10 +: 10];
   endfunction

   task automatic pkt_raise(input logic [1:0] idx, input logic [9:0] pay, input int bound,
                            output logic got, output logic err_seen);
      bus.rcv0_pakio = {idx, pay};
      bus.rcv0_req   = 1'b1;
      got            = 1'b0;
      err_seen       = 1'b0;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (bus.rcv0_ack === 1'b1) begin
            got      = 1'b1;
            err_seen = err;
            break;
         end
      end
   endtask

   task automatic pkt_drop();
      bus.rcv0_req = 1'b0;
      for (int i = 0; i < 10 && bus.rcv0_ack !== 1'b0; i++) tick();
      check("rcv_ack_low", bus.rcv0_ack, 0);
   endtask

   task automatic send_pkt(input logic [1:0] idx, input logic [9:0] pay, input logic exp_err);
      logic got, e;
      pkt_raise(idx, pay, 20, got, e);
      check("pkt_ack", got, 1);
      check("pkt_err", e, exp_err);
      pkt_drop();
   endtask

   task automatic send_msg(input vec_t v);
      for (int k = 0; k < 3; k++) send_pkt(2'(k), pkt_of(v.m, k), 1'b0);
   endtask

   task automatic wait_snd_req(input logic level, input int bound);
      for (int i = 0; i < bound && bus.snd0_req !== level; i++) tick();
      check("snd_req_level", bus.snd0_req, level);
   endtask

   task automatic check_fields(input vec_t v);
      check("snd_src", bus.snd0_src, v.src);
      check("snd_dst", bus.snd0_dst, v.dst);
      check("snd_dat", bus.snd0_dat, v.dat);
      check("snd_red", bus.snd0_red, v.red);
   endtask

   task automatic recv_msg(input vec_t v);
      wait_snd_req(1'b1, 40);
      check_fields(v);
      bus.snd0_ack = 1'b1;
      wait_snd_req(1'b0, 10);
      bus.snd0_ack = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic got, e, seen;

      vecs[0] = '{24'hA5C3F1, 6'h29, 6'h1C, 8'h3F, 4'h1};
      vecs[1] = '{24'h000000, 6'h00, 6'h00, 8'h00, 4'h0};
      vecs[2] = '{24'hFFFFFF, 6'h3F, 6'h3F, 8'hFF, 4'hF};
      vecs[3] = '{24'h123456, 6'h04, 6'h23, 8'h45, 4'h6};
      vecs[4] = '{24'hC0FFEE, 6'h30, 6'h0F, 8'hFE, 4'hE};

      rst_n          = 1'b0;
      bus.rcv0_pakio = '0;
      bus.rcv0_req   = 1'b0;
      bus.snd0_ack   = 1'b0;
      repeat (3) tick();
      check("rst_ready", ready, 0);
      check("rst_rcv_ack", bus.rcv0_ack, 0);
      check("rst_snd_req", bus.snd0_req, 0);
      check("rst_err", err, 0);
      check("rst_fields", {bus.snd0_src, bus.snd0_dst, bus.snd0_dat, bus.snd0_red}, 0);
      rst_n = 1'b1;
      tick();
      check("init_ready", ready, 1);

      // First message: snd0_req rises exactly one cycle after the last packet is pushed.
      send_pkt(2'd0, pkt_of(vecs[0].m, 0), 1'b0);
      send_pkt(2'd1, pkt_of(vecs[0].m, 1), 1'b0);
      pkt_raise(2'd2, pkt_of(vecs[0].m, 2), 20, got, e);
      check("last_ack", got, 1);
      check("push_snd_req_0", bus.snd0_req, 0);
      tick();
      check("push_snd_req_1", bus.snd0_req, 1);
      pkt_drop();
      recv_msg(vecs[0]);

      // Table of messages through the full path.
      for (int i = 0; i < 5; i++) begin
         send_msg(vecs[i]);
         recv_msg(vecs[i]);
      end

      // Sequence error 0,2: err on idx 2, nothing delivered; then a clean message.
      send_pkt(2'd0, pkt_of(vecs[0].m, 0), 1'b0);
      send_pkt(2'd2, pkt_of(vecs[0].m, 2), 1'b1);
      repeat (10) tick();
      check("seqerr_no_msg", bus.snd0_req, 0);
      send_msg(vecs[3]);
      recv_msg(vecs[3]);

      // Unexpected idx 0 restarts assembly with its own payload.
      send_pkt(2'd0, pkt_of(vecs[1].m, 0), 1'b0);
      send_pkt(2'd1, pkt_of(vecs[1].m, 1), 1'b0);
      send_pkt(2'd0, pkt_of(vecs[4].m, 0), 1'b1);
      send_pkt(2'd1, pkt_of(vecs[4].m, 1), 1'b0);
      send_pkt(2'd2, pkt_of(vecs[4].m, 2), 1'b0);
      recv_msg(vecs[4]);

      // Glitch one cycle shorter than the debounce window is ignored.
      send_pkt(2'd0, pkt_of(vecs[3].m, 0), 1'b0);
      bus.rcv0_pakio = {2'd0, pkt_of(vecs[2].m, 0)};
      bus.rcv0_req   = 1'b1;
      tick();
      bus.rcv0_req = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.rcv0_ack !== 1'b0 || err !== 1'b0) seen = 1'b1;
      end
      check("glitch_ignored", seen, 0);
      send_pkt(2'd1, pkt_of(vecs[3].m, 1), 1'b0);
      send_pkt(2'd2, pkt_of(vecs[3].m, 2), 1'b0);
      recv_msg(vecs[3]);

      // FIFO full: four messages buffered, fifth stalls on its last packet until a pop.
      for (int i = 0; i < 4; i++) send_msg(vecs[i]);
      send_pkt(2'd0, pkt_of(vecs[4].m, 0), 1'b0);
      send_pkt(2'd1, pkt_of(vecs[4].m, 1), 1'b0);
      pkt_raise(2'd2, pkt_of(vecs[4].m, 2), 20, got, e);
      check("full_stall", got, 0);
      recv_msg(vecs[0]);
      for (int i = 0; i < 20 && bus.rcv0_ack !== 1'b1; i++) tick();
      check("stall_release", bus.rcv0_ack, 1);
      pkt_drop();
      for (int i = 1; i < 5; i++) recv_msg(vecs[i]);

      // Reset mid-message with a message on offer: everything is discarded.
      send_msg(vecs[1]);
      wait_snd_req(1'b1, 20);
      send_pkt(2'd0, pkt_of(vecs[2].m, 0), 1'b0);
      pkt_raise(2'd1, pkt_of(vecs[2].m, 1), 20, got, e);
      check("pre_rst_ack", got, 1);
      rst_n = 1'b0;
      tick();
      check("midrst_rcv_ack", bus.rcv0_ack, 0);
      check("midrst_snd_req", bus.snd0_req, 0);
      check("midrst_ready", ready, 0);
      bus.rcv0_req = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("rerst_ready", ready, 1);
      repeat (8) tick();
      check("fifo_flushed", bus.snd0_req, 0);
      send_msg(vecs[2]);
      recv_msg(vecs[2]);

      // Push and pop on the same edge with two messages buffered.
      send_msg(vecs[0]);
      send_msg(vecs[1]);
      wait_snd_req(1'b1, 20);
      check_fields(vecs[0]);
      send_pkt(2'd0, pkt_of(vecs[2].m, 0), 1'b0);
      send_pkt(2'd1, pkt_of(vecs[2].m, 1), 1'b0);
      bus.rcv0_pakio = {2'd2, pkt_of(vecs[2].m, 2)};
      bus.rcv0_req   = 1'b1;
      bus.snd0_ack   = 1'b1;
      for (int i = 0; i < 10 && bus.rcv0_ack !== 1'b1; i++) tick();
      check("b2b_push", bus.rcv0_ack, 1);
      check("b2b_pop", bus.snd0_req, 0);
      bus.snd0_ack = 1'b0;
      pkt_drop();
      repeat (3) tick();
      recv_msg(vecs[1]);
      recv_msg(vecs[2]);
      repeat (10) tick();
      check("b2b_count", bus.snd0_req, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
